oc_packet_scheduler: RTL

Packet-level round-robin scheduler for one router output channel. It arbitrates among the NUMBER_CHANNELS crossbar requesters and holds the winner's grant until that packet's end-of-packet flit has been handed off downstream. It drives the data/valid switch selects and the output valid, and enforces a maximum packet length so a malformed packet cannot lock the port.

---
 rtl/oc_packet_scheduler_pkg.sv | 40 ++++
 rtl/oc_rr_pick.sv | 25 ++
 rtl/oc_packet_scheduler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/oc_packet_scheduler_pkg.sv
// Shared state encoding and round-robin helpers for the output-channel packet scheduler.
package oc_packet_scheduler_pkg;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  // Helpers work on a fixed-width vector; callers zero-extend their channel bits.
  localparam int unsigned MaxChannels = 32;
  localparam int unsigned IdxW        = $clog2(MaxChannels);

  function automatic int unsigned onehot_to_idx(input logic [MaxChannels-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxChannels; i++) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

  // First set bit of req found by walking upward from ptr, wrapping at n.
  function automatic int unsigned rr_search(input logic [MaxChannels-1:0] req,
                                            input int unsigned           ptr,
                                            input int unsigned           n);
    int unsigned cand;
    int unsigned win;
    logic        found;
    cand  = ptr;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxChannels; k++) begin
      if (!found && (k < n) && req[cand[IdxW-1:0]]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = (cand + 32'd1 >= n) ? 32'd0 : cand + 32'd1;
    end
    return win;
  endfunction

endpackage

// File: rtl/oc_rr_pick.sv
// Combinational round-robin picker: one-hot winner among req, searching upward from ptr.
module oc_rr_pick
  import oc_packet_scheduler_pkg::*;
#(
  parameter int unsigned NUMBER_CHANNELS = 5,
  parameter int unsigned PTR_W           = 3
) (
  input  logic [NUMBER_CHANNELS-1:0] req,
  input  logic [PTR_W-1:0]           ptr,
  output logic [NUMBER_CHANNELS-1:0] winner,
  output logic                       valid
);

  int unsigned win_idx;

  always_comb begin
    valid   = |req;
    win_idx = rr_search(MaxChannels'(req), 32'(ptr), NUMBER_CHANNELS);
    winner  = '0;
    for (int unsigned i = 0; i < NUMBER_CHANNELS; i++) begin
      winner[i] = valid && (win_idx == i);
    end
  end

endmodule

// File: rtl/oc_packet_scheduler.sv
// Packet-level round-robin scheduler for one router output channel; a grant is held
// until the packet's EOP flit is accepted downstream or the length limit forces release.
module oc_packet_scheduler
  import oc_packet_scheduler_pkg::*;
#(
  parameter int unsigned NUMBER_CHANNELS = 5,
  parameter int unsigned DATA_WIDTH      = 70,
  parameter int unsigned MAX_FLITS       = 64,
  parameter int unsigned CNT_W           = $clog2(MAX_FLITS + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUMBER_CHANNELS-1:0]         x_req,
  input  logic [NUMBER_CHANNELS-1:0]         x_rok,
  input  logic                               eop,
  input  logic                               out_ack,
  output logic [NUMBER_CHANNELS-1:0]         x_gnt,
  output logic [NUMBER_CHANNELS-1:0]         sel_channel,
  output logic                               idle,
  output logic                               out_val,
  output logic                               len_err,
  output logic [$clog2(NUMBER_CHANNELS)-1:0] ptr
);

  localparam int unsigned PtrW = $clog2(NUMBER_CHANNELS);

  if (NUMBER_CHANNELS < 2 || NUMBER_CHANNELS > MaxChannels) begin : g_bad_channels
    $error("oc_packet_scheduler: NUMBER_CHANNELS out of range");
  end
  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("oc_packet_scheduler: DATA_WIDTH must leave room for the EOP bit");
  end
  if (MAX_FLITS < 1) begin : g_bad_max
    $error("oc_packet_scheduler: MAX_FLITS must be at least 1");
  end

  logic [0:0]                 state_q, state_d;
  logic [NUMBER_CHANNELS-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PtrW-1:0]            ptr_q, ptr_d;
  logic                       len_err_q, len_err_d;

  logic [NUMBER_CHANNELS-1:0] pick;
  logic                       pick_valid;
  logic                       xfer;
  logic                       at_limit;
  logic                       pkt_done;
  logic [PtrW-1:0]            ptr_next;
  int unsigned                gnt_idx;

  oc_rr_pick #(
    .NUMBER_CHANNELS(NUMBER_CHANNELS),
    .PTR_W          (PtrW)
  ) u_rr_pick (
    .req   (x_req),
    .ptr   (ptr_q),
    .winner(pick),
    .valid (pick_valid)
  );

  // out_val depends only on the registered grant and x_rok.
  assign out_val  = |(gnt_q & x_rok);
  assign xfer     = (state_q == StBusy) && out_val && out_ack;
  assign at_limit = (cnt_q == CNT_W'(MAX_FLITS - 1));
  assign pkt_done = xfer && (eop || at_limit);

  always_comb begin
    gnt_idx  = onehot_to_idx(MaxChannels'(gnt_q));
    ptr_next = (gnt_idx + 32'd1 >= NUMBER_CHANNELS) ? '0 : PtrW'(gnt_idx + 32'd1);
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    len_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StBusy;
          gnt_d   = pick;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (pkt_done) begin
          state_d   = StIdle;
          gnt_d     = '0;
          cnt_d     = '0;
          ptr_d     = ptr_next;
          len_err_d = !eop;
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      len_err_q <= len_err_d;
    end
  end

  assign x_gnt       = gnt_q;
  assign sel_channel = gnt_q;
  assign idle        = (state_q == StIdle);
  assign len_err     = len_err_q;
  assign ptr         = ptr_q;

endmodule
